counter_to_datetime: RTL and testbench



---
 rtl/clock_pkg.sv | 35 +++
 rtl/bcd_inc.sv | 26 ++
 rtl/counter_to_datetime.sv | 191 +++++++++++++++++++
 tb/tb_counter_to_datetime.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants, FSM state encoding and calendar helpers for the clock datapath.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_HOUR,
    ST_MIN,
    ST_SEC,
    ST_YEAR,
    ST_MONTH,
    ST_DAY
  } state_t;

  localparam logic [16:0] SECS_PER_DAY   = 17'd86400;
  localparam logic [16:0] SECS_PER_HOUR  = 17'd3600;
  localparam logic [16:0] SECS_PER_MIN   = 17'd60;
  localparam logic [15:0] EPOCH_YEAR_BCD = 16'h1970;
  localparam logic [63:0] COUNTER_MAX    = 64'd4102444800;

  function automatic logic [4:0] month_days(input logic [7:0] mon_bcd, input logic leap);
    case (mon_bcd)
      8'h02:                      month_days = leap ? 5'd29 : 5'd28;
      8'h04, 8'h06, 8'h09, 8'h11: month_days = 5'd30;
      default:                    month_days = 5'd31;
    endcase
  endfunction

  function automatic logic [2:0] wd_add(input logic [2:0] wd, input logic [1:0] k);
    logic [3:0] s;
    s = {1'b0, wd} + {2'b00, k};
    return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
  endfunction

endpackage

// File: rtl/bcd_inc.sv
// N-digit BCD incrementer: adds one with a per-digit decimal carry chain.
module bcd_inc #(
  parameter int unsigned DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] i_val,
  output logic [4*DIGITS-1:0] o_val
);

  logic w_carry;

  always_comb begin
    w_carry = 1'b1;
    o_val   = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (w_carry && i_val[4*d +: 4] == 4'd9) begin
        o_val[4*d +: 4] = 4'd0;
      end else if (w_carry) begin
        o_val[4*d +: 4] = i_val[4*d +: 4] + 4'd1;
        w_carry         = 1'b0;
      end else begin
        o_val[4*d +: 4] = i_val[4*d +: 4];
      end
    end
  end

endmodule

// File: rtl/counter_to_datetime.sv
// Iterative epoch-seconds to BCD date/time decoder (divide, then subtract-and-count).
// Optional weekday output enabled by defining COUNTER_TO_DATETIME_WEEKDAY_EN.
module counter_to_datetime
  import clock_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] counter,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  minute_bcd,
  output logic [7:0]  second_bcd
`ifdef COUNTER_TO_DATETIME_WEEKDAY_EN
  ,
  output logic [2:0]  weekday
`endif
);

  state_t      r_state;
  logic [31:0] r_num;   // dividend during DIV, then remaining days
  logic [16:0] r_rem;   // seconds-of-day remainder
  logic [4:0]  r_cnt;
  logic [1:0]  r_leap;  // year mod 4 phase; 0 means leap
  logic [15:0] r_year;
  logic [7:0]  r_mon, r_day, r_hour, r_min, r_sec;

  logic [15:0] w_year_inc;
  logic [7:0]  w_mon_inc, w_day_inc, w_hour_inc, w_min_inc, w_sec_inc;
  logic [17:0] w_trial;
  logic        w_div_ge;
  logic [16:0] w_rem_next;
  logic        w_leap, w_in_range, w_year_step, w_mon_step, w_day_step;
  logic [8:0]  w_year_len;
  logic [4:0]  w_mon_len;

  bcd_inc #(.DIGITS(4)) u_inc_year (.i_val(r_year), .o_val(w_year_inc));
  bcd_inc #(.DIGITS(2)) u_inc_mon  (.i_val(r_mon),  .o_val(w_mon_inc));
  bcd_inc #(.DIGITS(2)) u_inc_day  (.i_val(r_day),  .o_val(w_day_inc));
  bcd_inc #(.DIGITS(2)) u_inc_hour (.i_val(r_hour), .o_val(w_hour_inc));
  bcd_inc #(.DIGITS(2)) u_inc_min  (.i_val(r_min),  .o_val(w_min_inc));
  bcd_inc #(.DIGITS(2)) u_inc_sec  (.i_val(r_sec),  .o_val(w_sec_inc));

  always_comb begin
    w_trial     = {r_rem, r_num[31]};
    w_div_ge    = w_trial >= 18'(SECS_PER_DAY);
    w_rem_next  = w_div_ge ? 17'(w_trial - 18'(SECS_PER_DAY)) : w_trial[16:0];
    w_leap      = (r_leap == 2'd0);
    w_year_len  = w_leap ? 9'd366 : 9'd365;
    w_mon_len   = month_days(r_mon, w_leap);
    w_in_range  = counter < COUNTER_MAX;
    w_year_step = r_num >= 32'(w_year_len);
    w_mon_step  = r_num >= 32'(w_mon_len);
    w_day_step  = r_num != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_leap     <= 2'd2;
      r_year     <= EPOCH_YEAR_BCD;
      r_mon      <= 8'h01;
      r_day      <= 8'h01;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      year_bcd   <= EPOCH_YEAR_BCD;
      month_bcd  <= 8'h01;
      day_bcd    <= 8'h01;
      hour_bcd   <= '0;
      minute_bcd <= '0;
      second_bcd <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_in_range) begin
            r_num   <= counter[31:0];
            r_rem   <= '0;
            r_cnt   <= '0;
            r_leap  <= 2'd2;
            r_year  <= EPOCH_YEAR_BCD;
            r_mon   <= 8'h01;
            r_day   <= 8'h01;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            busy    <= 1'b1;
            r_state <= ST_DIV;
          end else if (start) begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        ST_DIV: begin
          // Quotient bits shift into r_num as the dividend bits shift out.
          r_rem <= w_rem_next;
          r_num <= {r_num[30:0], w_div_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= ST_HOUR;
        end
        ST_HOUR: begin
          if (r_rem >= SECS_PER_HOUR) begin
            r_rem  <= r_rem - SECS_PER_HOUR;
            r_hour <= w_hour_inc;
          end else r_state <= ST_MIN;
        end
        ST_MIN: begin
          if (r_rem >= SECS_PER_MIN) begin
            r_rem <= r_rem - SECS_PER_MIN;
            r_min <= w_min_inc;
          end else r_state <= ST_SEC;
        end
        ST_SEC: begin
          if (r_rem != '0) begin
            r_rem <= r_rem - 17'd1;
            r_sec <= w_sec_inc;
          end else r_state <= ST_YEAR;
        end
        ST_YEAR: begin
          if (w_year_step) begin
            r_num  <= r_num - 32'(w_year_len);
            r_year <= w_year_inc;
            r_leap <= r_leap + 2'd1;
          end else r_state <= ST_MONTH;
        end
        ST_MONTH: begin
          if (w_mon_step) begin
            r_num <= r_num - 32'(w_mon_len);
            r_mon <= w_mon_inc;
          end else r_state <= ST_DAY;
        end
        ST_DAY: begin
          if (w_day_step) begin
            r_num <= r_num - 32'd1;
            r_day <= w_day_inc;
          end else begin
            year_bcd   <= r_year;
            month_bcd  <= r_mon;
            day_bcd    <= r_day;
            hour_bcd   <= r_hour;
            minute_bcd <= r_min;
            second_bcd <= r_sec;
            done       <= 1'b1;
            err        <= 1'b0;
            busy       <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef COUNTER_TO_DATETIME_WEEKDAY_EN
  logic [2:0] r_wd;

  // Mirrors the FSM step conditions; each subtracted period advances by its length mod 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd    <= 3'd4;
      weekday <= 3'd4;
    end else begin
      case (r_state)
        ST_IDLE:  if (start && w_in_range) r_wd <= 3'd4;
        ST_YEAR:  if (w_year_step) r_wd <= wd_add(r_wd, w_leap ? 2'd2 : 2'd1);
        ST_MONTH: if (w_mon_step) r_wd <= wd_add(r_wd, 2'(w_mon_len - 5'd28));
        ST_DAY: begin
          if (w_day_step) r_wd <= wd_add(r_wd, 2'd1);
          else            weekday <= r_wd;
        end
        default: ;
      endcase
    end
  end
`else
  // No weekday tracking in this build.
`endif

endmodule

// File: tb/tb_counter_to_datetime.sv
// Directed-vector bench for counter_to_datetime; weekday checks follow COUNTER_TO_DATETIME_WEEKDAY_EN.
module tb_counter_to_datetime;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] counter = '0;
  logic        busy, done, err;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
`ifdef COUNTER_TO_DATETIME_WEEKDAY_EN
  logic [2:0]  weekday;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  counter_to_datetime dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .counter    (counter),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .year_bcd   (year_bcd),
    .month_bcd  (month_bcd),
    .day_bcd    (day_bcd),
    .hour_bcd   (hour_bcd),
    .minute_bcd (minute_bcd),
    .second_bcd (second_bcd)
`ifdef COUNTER_TO_DATETIME_WEEKDAY_EN
    ,
    .weekday    (weekday)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dt(input string tag, input logic [15:0] y, input logic [7:0] mo,
                          input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                          input logic [7:0] s, input logic [2:0] wd);
    check({tag, "_year"}, year_bcd, y);
    check({tag, "_month"}, month_bcd, mo);
    check({tag, "_day"}, day_bcd, d);
    check({tag, "_hour"}, hour_bcd, h);
    check({tag, "_min"}, minute_bcd, mi);
    check({tag, "_sec"}, second_bcd, s);
`ifdef COUNTER_TO_DATETIME_WEEKDAY_EN
    check({tag, "_wday"}, weekday, wd);
`else
    if (wd > 3'd6) $display("note: bad weekday vector for %s", tag);
`endif
  endtask

  // Latency = clock edges after the edge that samples start until done is seen.
  task automatic run_conv(input string tag, input logic [63:0] cnt, input logic exp_busy,
                          input int glitch_at, output int lat);
    counter = cnt;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    check({tag, "_busy_rise"}, busy, exp_busy);
    while (!done && lat < 500) begin
      if (glitch_at != 0 && lat == glitch_at) begin
        start   = 1'b1;
        counter = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
  endtask

  typedef struct {
    string       tag;
    logic [63:0] cnt;
    int          lat;
    logic [15:0] y;
    logic [7:0]  mo, d, h, mi, s;
    logic [2:0]  wd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int done_cnt;

    vecs[0] = '{"epoch",  64'd0,          38,  16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd4};
    vecs[1] = '{"eoy23",  64'd1704067199, 273, 16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 3'd0};
    vecs[2] = '{"ny24",   64'd1704067200, 92,  16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1};
    vecs[3] = '{"leap24", 64'd1709164800, 121, 16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 3'd4};
    vecs[4] = '{"gig",    64'd1000000000, 172, 16'h2001, 8'h09, 8'h09, 8'h01, 8'h46, 8'h40, 3'd0};
    vecs[5] = '{"max",    64'd4102444799, 349, 16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 3'd4};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check_dt("rst", 16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd4);

    foreach (vecs[i]) begin
      run_conv(vecs[i].tag, vecs[i].cnt, 1'b1, 0, lat);
      check({vecs[i].tag, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].tag, "_err"}, err, 0);
      check({vecs[i].tag, "_busy_fall"}, busy, 0);
      check_dt(vecs[i].tag, vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi,
               vecs[i].s, vecs[i].wd);
      @(posedge clk); #1;
      check({vecs[i].tag, "_done_pulse"}, done, 0);
    end

    // Out-of-range: done/err immediately, date held from the 2099 result.
    run_conv("oor", 64'd4102444800, 1'b0, 0, lat);
    check("oor_latency", 64'(lat), 0);
    check("oor_err", err, 1);
    check_dt("oor", 16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 3'd4);
    @(posedge clk); #1;
    check("oor_done_pulse", done, 0);
    check("oor_err_level", err, 1);

    // Reset 50 cycles into a conversion.
    counter = 64'd4102444799;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check_dt("midrst", 16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd4);
    done_cnt = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 0);

    // start pulsed while busy must not disturb the running conversion.
    run_conv("ignore", 64'd1704067200, 1'b1, 10, lat);
    check("ignore_latency", 64'(lat), 92);
    check("ignore_err", err, 0);
    check_dt("ignore", 16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
